// File: rtl/ppu_dot_timing.sv
// NTSC PPU raster timing: dot/scanline counter advanced on each PPU enable,
// with visible decode, vblank/NMI generation and line/frame strobes.
module ppu_dot_timing #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VISIBLE_DOTS    = 256,
  parameter int VISIBLE_LINES   = 240,
  parameter int VBLANK_LINE     = 241,
  parameter int ODD_SKIP_EN     = 1
) (
  input  logic       i_clk_mst,
  input  logic       i_rst_mst_n,
  input  logic       i_clk_en_ppu,
  input  logic       i_rendering_en,
  input  logic       i_nmi_en,
  input  logic       i_status_rd,
  output logic [8:0] o_dot,
  output logic [8:0] o_scanline,
  output logic       o_visible,
  output logic       o_vblank_flag,
  output logic       o_nmi_n,
  output logic       o_frame_odd,
  output logic       o_line_start,
  output logic       o_frame_start
);
  localparam logic [8:0] NDOTS     = 9'(DOTS_PER_LINE);
  localparam logic [8:0] NLINES    = 9'(LINES_PER_FRAME);
  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] PRE_LINE  = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VIS_DOTS  = 9'(VISIBLE_DOTS);
  localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
  localparam logic [8:0] VBL_LINE  = 9'(VBLANK_LINE);

  logic [8:0] r_dot, r_line;
  logic       r_odd, r_vbl, r_nmi_n, r_vis, r_ls, r_fs;
  logic [8:0] w_nxt_dot, w_nxt_line;
  logic       w_skip, w_wrap, w_vis_nxt, w_set, w_clr;

  assign w_skip = (ODD_SKIP_EN != 0) && r_odd && i_rendering_en &&
                  (r_line == PRE_LINE) && (r_dot == SKIP_DOT);

  // Out-of-range positions fall back to the frame origin.
  always_comb begin
    w_nxt_dot  = r_dot + 9'd1;
    w_nxt_line = r_line;
    if (r_dot >= NDOTS || r_line >= NLINES || w_skip) begin
      w_nxt_dot  = 9'd0;
      w_nxt_line = 9'd0;
    end else if (r_dot == LAST_DOT) begin
      w_nxt_dot  = 9'd0;
      w_nxt_line = (r_line == PRE_LINE) ? 9'd0 : r_line + 9'd1;
    end
  end

  assign w_wrap    = (w_nxt_dot == 9'd0) && (w_nxt_line == 9'd0);
  assign w_vis_nxt = (w_nxt_line < VIS_LINES) && (w_nxt_dot != 9'd0) &&
                     (w_nxt_dot <= VIS_DOTS);
  assign w_set     = i_clk_en_ppu && (r_line == VBL_LINE) && (r_dot == 9'd0);
  assign w_clr     = i_clk_en_ppu && (r_line == PRE_LINE) && (r_dot == 9'd0);

  always_ff @(posedge i_clk_mst) begin
    if (!i_rst_mst_n) begin
      r_dot   <= 9'd0;
      r_line  <= 9'd0;
      r_odd   <= 1'b0;
      r_vbl   <= 1'b0;
      r_nmi_n <= 1'b1;
      r_vis   <= 1'b0;
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
    end else begin
      r_nmi_n <= ~(r_vbl & i_nmi_en);
      r_ls    <= 1'b0;
      r_fs    <= 1'b0;
      if (i_clk_en_ppu) begin
        r_dot  <= w_nxt_dot;
        r_line <= w_nxt_line;
        r_vis  <= w_vis_nxt;
        r_ls   <= (w_nxt_dot == 9'd0);
        r_fs   <= w_wrap;
        if (w_wrap) r_odd <= ~r_odd;
      end
      // A status read on the set tick wins, so the flag misses this frame.
      if (i_status_rd)  r_vbl <= 1'b0;
      else if (w_clr)   r_vbl <= 1'b0;
      else if (w_set)   r_vbl <= 1'b1;
    end
  end

  assign o_dot         = r_dot;
  assign o_scanline    = r_line;
  assign o_visible     = r_vis;
  assign o_vblank_flag = r_vbl;
  assign o_nmi_n       = r_nmi_n;
  assign o_frame_odd   = r_odd;
  assign o_line_start  = r_ls;
  assign o_frame_start = r_fs;
endmodule

// File: tb/tb_ppu_dot_timing.sv
// Randomised and directed bench for ppu_dot_timing against a frame-index model.
module tb_ppu_dot_timing;
  localparam int D = 20, L = 12, VD = 16, VL = 8, VB = 9;
  localparam int FLEN = D * L;

  logic clk = 0;
  logic rst_n = 0, en = 0, rend = 0, nmien = 0, rd = 0;
  logic [8:0] dot, line, ddot, dline;
  logic vis, vbl, nmi_n, odd, ls, fs;
  logic dvis, dvbl, dnmi, dodd, dls, dfs;

  ppu_dot_timing #(.DOTS_PER_LINE(D), .LINES_PER_FRAME(L), .VISIBLE_DOTS(VD),
                   .VISIBLE_LINES(VL), .VBLANK_LINE(VB), .ODD_SKIP_EN(1)) u_dut (
    .i_clk_mst(clk), .i_rst_mst_n(rst_n), .i_clk_en_ppu(en), .i_rendering_en(rend),
    .i_nmi_en(nmien), .i_status_rd(rd), .o_dot(dot), .o_scanline(line),
    .o_visible(vis), .o_vblank_flag(vbl), .o_nmi_n(nmi_n), .o_frame_odd(odd),
    .o_line_start(ls), .o_frame_start(fs));

  ppu_dot_timing u_def (
    .i_clk_mst(clk), .i_rst_mst_n(rst_n), .i_clk_en_ppu(en), .i_rendering_en(rend),
    .i_nmi_en(nmien), .i_status_rd(rd), .o_dot(ddot), .o_scanline(dline),
    .o_visible(dvis), .o_vblank_flag(dvbl), .o_nmi_n(dnmi), .o_frame_odd(dodd),
    .o_line_start(dls), .o_frame_start(dfs));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: position is a linear index into the frame.
  int mk = 0; bit modd = 0, mvbl = 0, mnmi = 1, mvis = 0, mls = 0, mfs = 0;
  always @(posedge clk) begin
    bit set, clr; int nk;
    if (!rst_n) begin
      mk = 0; modd = 0; mvbl = 0; mnmi = 1; mvis = 0; mls = 0; mfs = 0;
    end else begin
      mnmi = !(mvbl && nmien);
      mls = 0; mfs = 0; set = 0; clr = 0;
      if (en) begin
        set = (mk == VB * D);
        clr = (mk == (L - 1) * D);
        if (modd && rend && mk == FLEN - 2) nk = 0;
        else nk = (mk + 1) % FLEN;
        mk = nk;
        if (nk == 0) modd = !modd;
        mls = (mk % D) == 0;
        mfs = (mk == 0);
        mvis = (mk / D) < VL && (mk % D) >= 1 && (mk % D) <= VD;
      end
      if (rd) mvbl = 0;
      else if (clr) mvbl = 0;
      else if (set) mvbl = 1;
    end
  end

  // Frame length in enables, measured between frame_start pulses.
  int cnt = 0; int lens[$]; bit pars[$];
  always @(posedge clk) if (!rst_n) cnt = 0; else if (en) cnt++;

  bit chk_on = 0;
  always @(negedge clk) begin
    if (chk_on) begin
      chk("dot", int'(dot), mk % D);
      chk("scanline", int'(line), mk / D);
      chk("visible", int'(vis), int'(mvis));
      chk("vblank_flag", int'(vbl), int'(mvbl));
      chk("nmi_n", int'(nmi_n), int'(mnmi));
      chk("frame_odd", int'(odd), int'(modd));
      chk("line_start", int'(ls), int'(mls));
      chk("frame_start", int'(fs), int'(mfs));
    end
    if (fs === 1'b1) begin
      lens.push_back(cnt); pars.push_back(!odd); cnt = 0;
    end
  end

  task automatic wait_k(input int t, input bit need_odd, input string nm);
    int n = 0;
    forever begin
      @(negedge clk);
      if (mk == t && (!need_odd || modd)) break;
      en = 1;
      if (++n > 3 * FLEN) begin chk({nm, "_timeout"}, 0, 1); break; end
    end
  endtask

  task automatic wait_fs(input int n, input int every);
    int c = 0;
    lens.delete(); pars.delete();
    while (lens.size() < n) begin
      @(negedge clk);
      c++;
      en = (c % every) == 0;
      if (c > 4 * every * FLEN) begin chk("frame_wait_timeout", 0, 1); break; end
    end
  endtask

  initial begin
    int seen;
    // Reset with enables toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk_on = 1; en = i[0];
    end
    @(negedge clk);
    chk("rst_dot", int'(dot), 0); chk("rst_line", int'(line), 0);
    chk("rst_vbl", int'(vbl), 0); chk("rst_nmi", int'(nmi_n), 1);
    chk("rst_odd", int'(odd), 0);
    rst_n = 1; en = 1;
    @(negedge clk);
    chk("first_dot", int'(dot), 1); chk("first_vis", int'(vis), 1);
    repeat (339) @(negedge clk);
    chk("def_dot340", int'(ddot), 340);
    @(negedge clk);
    chk("def_dot0", int'(ddot), 0); chk("def_line1", int'(dline), 1);
    chk("def_ls", int'(dls), 1);

    // Enable every 4th cycle, rendering off: every frame is full length
    rend = 0;
    wait_fs(3, 4);
    chk("gap_len1", lens[1], FLEN); chk("gap_len2", lens[2], FLEN);
    chk("gap_parity", int'(pars[1] ^ pars[2]), 1);

    // Rendering on: odd frames drop one dot
    rend = 1;
    wait_fs(3, 1);
    for (int i = 1; i < 3; i++) chk("skip_len", lens[i], pars[i] ? FLEN - 1 : FLEN);
    chk("skip_parity", int'(pars[1] ^ pars[2]), 1);

    // Vblank / NMI with a status read mid-vblank
    nmien = 1;
    wait_k(VB * D + 1, 0, "vbl_set");
    chk("vbl_set", int'(vbl), 1); chk("vbl_dot", int'(dot), 1);
    chk("vbl_line", int'(line), VB);
    @(negedge clk);
    chk("nmi_low", int'(nmi_n), 0);
    wait_k(10 * D + 5, 0, "rd_pos");
    rd = 1;
    @(negedge clk); rd = 0;
    chk("rd_clr", int'(vbl), 0);
    @(negedge clk);
    chk("rd_nmi", int'(nmi_n), 1);

    // Race: read on the set tick suppresses the flag for the whole frame
    wait_k(VB * D, 0, "race_pos");
    rd = 1; en = 1;
    @(negedge clk); rd = 0;
    seen = 0;
    while (mk != 0) begin
      if (vbl || !nmi_n) seen++;
      @(negedge clk);
      if (seen > FLEN) break;
    end
    chk("race_suppressed", seen, 0);
    wait_k(VB * D + 1, 0, "race_next");
    chk("race_next_set", int'(vbl), 1);
    wait_k((L - 1) * D + 1, 0, "vbl_rel");
    chk("vbl_release", int'(vbl), 0);
    @(negedge clk);
    chk("nmi_release", int'(nmi_n), 1);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      en    = ($urandom % 3) != 0;
      rend  = ($urandom % 4) != 0;
      rd    = ($urandom % 60) == 0;
      if ($urandom % 200 == 0) nmien = ~nmien;
      rst_n = ($urandom % 1500) != 0;
    end
    rd = 0; rst_n = 1;

    // Mid-frame reset on an odd frame
    wait_k(5 * D + 10, 1, "odd_pos");
    rst_n = 0; en = 1;
    @(negedge clk);
    chk("mrst_dot", int'(dot), 0); chk("mrst_line", int'(line), 0);
    chk("mrst_odd", int'(odd), 0); chk("mrst_vbl", int'(vbl), 0);
    chk("mrst_fs", int'(fs), 0);
    @(negedge clk);
    chk("mrst_fs2", int'(fs), 0);
    rst_n = 1;
    repeat (20) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
